// File: rtl/alu_seq_pkg.sv
// Shared opcode, ALU-select, state and instruction-class definitions for the ALU sequencer.
// COND_BRANCH_EN (see alu_seq_decode) enables the JC/JZ conditional jumps.
package alu_seq_pkg;

  localparam int DataW = 8;
  localparam int OpW   = 4;

  localparam logic [OpW-1:0] OP_NOP = 4'b0000;
  localparam logic [OpW-1:0] OP_NOT = 4'b0101;
  localparam logic [OpW-1:0] OP_SUB = 4'b0110;
  localparam logic [OpW-1:0] OP_ADD = 4'b1001;
  localparam logic [OpW-1:0] OP_MOV = 4'b1010;
  localparam logic [OpW-1:0] OP_AND = 4'b1011;
  localparam logic [OpW-1:0] OP_JMP = 4'b1100;
  localparam logic [OpW-1:0] OP_JC  = 4'b1101;
  localparam logic [OpW-1:0] OP_JZ  = 4'b1110;
  localparam logic [OpW-1:0] OP_HLT = 4'b1111;

  // ALU select values coincide with the opcodes of the ALU instructions.
  localparam logic [OpW-1:0] ALU_S_PASS = 4'b0000;
  localparam logic [OpW-1:0] ALU_S_ADD  = OP_ADD;
  localparam logic [OpW-1:0] ALU_S_SUB  = OP_SUB;
  localparam logic [OpW-1:0] ALU_S_AND  = OP_AND;
  localparam logic [OpW-1:0] ALU_S_NOT  = OP_NOT;
  localparam logic [OpW-1:0] ALU_S_MOV  = OP_MOV;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_OPND   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP = 3'd0,
    CLS_ALU = 3'd1,
    CLS_JMP = 3'd2,
    CLS_JC  = 3'd3,
    CLS_JZ  = 3'd4,
    CLS_HLT = 3'd5
  } iclass_e;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decode: instruction class, ALU select and flag-update enable.
// Without COND_BRANCH_EN the JC/JZ opcodes fall through to single-byte NOP.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [OpW-1:0] opcode_i,
  output iclass_e        iclass_o,
  output logic [OpW-1:0] alu_s_o,
  output logic           flag_upd_o
);

  always_comb begin
    iclass_o   = CLS_NOP;
    alu_s_o    = ALU_S_PASS;
    flag_upd_o = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        iclass_o   = CLS_ALU;
        alu_s_o    = ALU_S_ADD;
        flag_upd_o = 1'b1;
      end
      OP_SUB: begin
        iclass_o   = CLS_ALU;
        alu_s_o    = ALU_S_SUB;
        flag_upd_o = 1'b1;
      end
      OP_AND: begin
        iclass_o = CLS_ALU;
        alu_s_o  = ALU_S_AND;
      end
      OP_NOT: begin
        iclass_o = CLS_ALU;
        alu_s_o  = ALU_S_NOT;
      end
      OP_MOV: begin
        iclass_o = CLS_ALU;
        alu_s_o  = ALU_S_MOV;
      end
      OP_JMP: iclass_o = CLS_JMP;
`ifdef COND_BRANCH_EN
      OP_JC:  iclass_o = CLS_JC;
      OP_JZ:  iclass_o = CLS_JZ;
`endif
      OP_HLT: iclass_o = CLS_HLT;
      default: iclass_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer fetching byte instructions and steering an external ALU/register file.
// Build option COND_BRANCH_EN enables JC/JZ; otherwise they execute as NOP.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             mem_req,
  output logic [DataW-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [DataW-1:0] mem_rdata,
  output logic             alu_m,
  output logic [OpW-1:0]   alu_s,
  input  logic             alu_cf,
  input  logic             alu_zf,
  output logic [1:0]       rs_sel,
  output logic [1:0]       rd_sel,
  output logic             rf_we,
  output logic [DataW-1:0] pc,
  output logic             cf_q,
  output logic             zf_q,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [DataW-1:0] pc_q, pc_d;
  logic [DataW-1:0] ir_q, ir_d;
  logic             cf_d, zf_d;

  iclass_e          iclass;
  logic [OpW-1:0]   dec_alu_s;
  logic             flag_upd;
  logic             branch_taken;

  alu_seq_decode u_decode (
    .opcode_i   (ir_q[7:4]),
    .iclass_o   (iclass),
    .alu_s_o    (dec_alu_s),
    .flag_upd_o (flag_upd)
  );

  assign branch_taken = (iclass == CLS_JMP)
                      | ((iclass == CLS_JC) & cf_q)
                      | ((iclass == CLS_JZ) & zf_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cf_d    = cf_q;
    zf_d    = zf_q;
    mem_req = 1'b0;
    alu_m   = 1'b0;
    alu_s   = ALU_S_PASS;
    rf_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (iclass)
          CLS_ALU:                 state_d = S_EXEC;
          CLS_JMP, CLS_JC, CLS_JZ: state_d = S_OPND;
          CLS_HLT:                 state_d = S_IDLE;
          default:                 state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        alu_m = 1'b1;
        alu_s = dec_alu_s;
        if (flag_upd) begin
          cf_d = alu_cf;
          zf_d = alu_zf;
        end
        state_d = S_WB;
      end
      S_WB: begin
        alu_m   = 1'b1;
        alu_s   = dec_alu_s;
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_OPND: begin
        // pc already points at the target byte, so a not-taken branch skips it.
        mem_req = 1'b1;
        if (mem_ack) begin
          pc_d    = branch_taken ? mem_rdata : pc_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign rs_sel   = ir_q[3:2];
  assign rd_sel   = ir_q[1:0];
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios then random programs vs an instruction-level model.
// Expectations for JC/JZ follow whether COND_BRANCH_EN is defined for the build.
module tb_alu_sequencer;

  localparam int C_NOP = 0;
  localparam int C_ALU = 1;
  localparam int C_JMP = 2;
  localparam int C_JC  = 3;
  localparam int C_JZ  = 4;
  localparam int C_HLT = 5;

  logic       clk = 1'b0;
  logic       rst_n, start, mem_ack, alu_cf, alu_zf;
  logic [7:0] mem_rdata;
  logic       mem_req, alu_m, rf_we, cf_q, zf_q, busy;
  logic [7:0] mem_addr, pc;
  logic [3:0] alu_s;
  logic [1:0] rs_sel, rd_sel;

  logic [7:0] mem [256];
  logic [7:0] pcM;
  logic       cfM, zfM;
  int         nCompared = 0;
  int         nMismatched = 0;

  alu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .alu_m     (alu_m),
    .alu_s     (alu_s),
    .alu_cf    (alu_cf),
    .alu_zf    (alu_zf),
    .rs_sel    (rs_sel),
    .rd_sel    (rd_sel),
    .rf_we     (rf_we),
    .pc        (pc),
    .cf_q      (cf_q),
    .zf_q      (zf_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a falling edge and sampled by the DUT on the next rising edge.
  task automatic applyStimulus(input logic ack, input logic [7:0] rdata, input logic st,
                               input logic cf, input logic zf);
    mem_ack   = ack;
    mem_rdata = rdata;
    start     = st;
    alu_cf    = cf;
    alu_zf    = zf;
    @(negedge clk);
  endtask

  function automatic int classify(input logic [3:0] op);
    case (op)
      4'b1001, 4'b0110, 4'b1011, 4'b0101, 4'b1010: return C_ALU;
      4'b1100: return C_JMP;
`ifdef COND_BRANCH_EN
      4'b1101: return C_JC;
      4'b1110: return C_JZ;
`endif
      4'b1111: return C_HLT;
      default: return C_NOP;
    endcase
  endfunction

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_pc"}, pc, 0);
    checkOutput({tag, "_addr"}, mem_addr, 0);
    checkOutput({tag, "_req"}, mem_req, 0);
    checkOutput({tag, "_alum"}, alu_m, 0);
    checkOutput({tag, "_alus"}, alu_s, 0);
    checkOutput({tag, "_we"}, rf_we, 0);
    checkOutput({tag, "_cf"}, cf_q, 0);
    checkOutput({tag, "_zf"}, zf_q, 0);
  endtask

  // Reset with noisy inputs, idle one cycle without start, then start; ends in FETCH.
  task automatic doReset();
    rst_n = 1'b0; start = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hFF; alu_cf = 1'b1; alu_zf = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkResetValues("rst");
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
    checkResetValues("idle");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    pcM = 8'h00; cfM = 1'b0; zfM = 1'b0;
  endtask

  // Runs one instruction from FETCH entry to the next FETCH, checking each cycle's outputs.
  task automatic execInstr(input int fwait, input int owait, input logic cfIn, input logic zfIn);
    logic [7:0] b, tgt;
    logic [3:0] op;
    logic       taken;
    int         cls;
    for (int i = 0; i < fwait; i++) begin
      checkOutput("fetch_wait_req", mem_req, 1);
      checkOutput("fetch_wait_pc", pc, pcM);
      applyStimulus(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    checkOutput("fetch_req", mem_req, 1);
    checkOutput("fetch_addr", mem_addr, pcM);
    checkOutput("fetch_busy", busy, 1);
    checkOutput("fetch_alum", alu_m, 0);
    checkOutput("fetch_we", rf_we, 0);
    checkOutput("fetch_alus", alu_s, 0);
    b = mem[pcM];
    applyStimulus(1'b1, b, 1'($urandom), 1'($urandom), 1'($urandom));
    pcM = pcM + 8'd1;
    op  = b[7:4];
    cls = classify(op);
    checkOutput("dec_req", mem_req, 0);
    checkOutput("dec_pc", pc, pcM);
    checkOutput("dec_busy", busy, 1);
    checkOutput("dec_alum", alu_m, 0);
    checkOutput("dec_we", rf_we, 0);
    applyStimulus(1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    case (cls)
      C_ALU: begin
        checkOutput("exec_alum", alu_m, 1);
        checkOutput("exec_alus", alu_s, op);
        checkOutput("exec_rs", rs_sel, b[3:2]);
        checkOutput("exec_rd", rd_sel, b[1:0]);
        checkOutput("exec_we", rf_we, 0);
        checkOutput("exec_req", mem_req, 0);
        applyStimulus(1'b1, 8'($urandom), 1'($urandom), cfIn, zfIn);
        if (op == 4'b1001 || op == 4'b0110) begin
          cfM = cfIn;
          zfM = zfIn;
        end
        checkOutput("wb_we", rf_we, 1);
        checkOutput("wb_alum", alu_m, 1);
        checkOutput("wb_alus", alu_s, op);
        checkOutput("wb_rs", rs_sel, b[3:2]);
        checkOutput("wb_rd", rd_sel, b[1:0]);
        checkOutput("wb_req", mem_req, 0);
        checkOutput("wb_cf", cf_q, cfM);
        checkOutput("wb_zf", zf_q, zfM);
        applyStimulus(1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      C_JMP, C_JC, C_JZ: begin
        for (int i = 0; i < owait; i++) begin
          checkOutput("opnd_wait_req", mem_req, 1);
          checkOutput("opnd_wait_addr", mem_addr, pcM);
          applyStimulus(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        checkOutput("opnd_req", mem_req, 1);
        checkOutput("opnd_addr", mem_addr, pcM);
        checkOutput("opnd_alum", alu_m, 0);
        checkOutput("opnd_we", rf_we, 0);
        tgt   = mem[pcM];
        taken = (cls == C_JMP) || (cls == C_JC && cfM) || (cls == C_JZ && zfM);
        applyStimulus(1'b1, tgt, 1'($urandom), 1'($urandom), 1'($urandom));
        pcM = taken ? tgt : pcM + 8'd1;
      end
      C_HLT: begin
        checkOutput("hlt_busy", busy, 0);
        checkOutput("hlt_req", mem_req, 0);
        checkOutput("hlt_pc", pc, pcM);
        applyStimulus(1'b1, 8'($urandom), 1'b0, 1'($urandom), 1'($urandom));
        checkOutput("hlt_hold_busy", busy, 0);
        applyStimulus(1'b0, 8'($urandom), 1'b1, 1'($urandom), 1'($urandom));
      end
      default: ;
    endcase
    checkOutput("next_fetch_req", mem_req, 1);
    checkOutput("next_fetch_pc", pc, pcM);
    checkOutput("next_fetch_cf", cf_q, cfM);
    checkOutput("next_fetch_zf", zf_q, zfM);
  endtask

  initial begin
    logic [7:0] expPc;

    // ADD r1->r0 with carry set, then AND leaves the carry alone.
    clearMem();
    mem[0] = 8'h94; mem[1] = 8'hB4;
    doReset();
    execInstr(0, 0, 1'b1, 1'b0);
    checkOutput("add_cf", cf_q, 1);
    checkOutput("add_pc", pc, 8'h01);
    execInstr(0, 0, 1'b0, 1'b1);
    checkOutput("and_keeps_cf", cf_q, 1);
    checkOutput("and_keeps_zf", zf_q, 0);

    // SUB sets zero, then JZ 0x40.
    clearMem();
    mem[0] = 8'h61; mem[1] = 8'hE0; mem[2] = 8'h40;
    doReset();
    execInstr(0, 0, 1'b0, 1'b1);
    execInstr(2, 1, 1'b0, 1'b0);
`ifdef COND_BRANCH_EN
    expPc = 8'h40;
`else
    execInstr(0, 0, 1'b0, 1'b0);
    expPc = 8'h03;
`endif
    checkOutput("jz_taken_pc", pc, expPc);

    // SUB clears zero, JZ falls through past its target byte.
    doReset();
    execInstr(0, 0, 1'b1, 1'b0);
    execInstr(0, 0, 1'b0, 1'b0);
`ifndef COND_BRANCH_EN
    execInstr(0, 0, 1'b0, 1'b0);
`endif
    checkOutput("jz_not_taken_pc", pc, 8'h03);

    // NOP fetched at 0xFF wraps pc to 0x00.
    clearMem();
    mem[0] = 8'hC0; mem[1] = 8'hFF; mem[255] = 8'h00;
    doReset();
    execInstr(0, 0, 1'b0, 1'b0);
    checkOutput("jmp_pc", pc, 8'hFF);
    execInstr(0, 0, 1'b0, 1'b0);
    checkOutput("nop_wrap_pc", pc, 8'h00);

    // JC at 0xFE not taken: target byte at 0xFF, fall-through wraps to 0x00.
    clearMem();
    mem[0] = 8'hC0; mem[1] = 8'hFE; mem[254] = 8'hD0; mem[255] = 8'h05;
    doReset();
    execInstr(0, 0, 1'b0, 1'b0);
    execInstr(0, 0, 1'b0, 1'b0);
`ifndef COND_BRANCH_EN
    checkOutput("d0_as_nop_pc", pc, 8'hFF);
    execInstr(0, 0, 1'b0, 1'b0);
`endif
    checkOutput("jc_wrap_pc", pc, 8'h00);

    // HLT returns to IDLE and restart resumes at the following byte.
    clearMem();
    mem[0] = 8'hF0; mem[1] = 8'h94;
    doReset();
    execInstr(0, 0, 1'b0, 1'b0);
    checkOutput("hlt_resume_pc", pc, 8'h01);
    execInstr(1, 0, 1'b0, 1'b1);
    checkOutput("after_hlt_zf", zf_q, 1);

    // Withheld ack stalls FETCH; asynchronous reset mid-wait discards the pending fetch.
    clearMem();
    mem[0] = 8'h00; mem[1] = 8'h00;
    doReset();
    execInstr(5, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
      checkOutput("stall_pc", pc, 8'h01);
      checkOutput("stall_req", mem_req, 1);
    end
    #2;
    mem_ack = 1'b1;
    rst_n   = 1'b0;
    #1;
    checkResetValues("async_rst");

    // Random programs with random wait states and random ALU flags.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    doReset();
    for (int n = 0; n < 300; n++) begin
      execInstr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: none; datapath width is fixed at 8 bits and opcode width at 4 bits.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 start  in  1  leave IDLE and begin fetching at current pc.
REQ-005 mem_req  out  1  instruction/operand byte request.
REQ-006 mem_addr  out  8  byte address; always equal to pc.
REQ-007 mem_ack  in  1  byte valid on mem_rdata this cycle; ignored when mem_req=0.
REQ-008 mem_rdata  in  8  fetched byte.
REQ-009 alu_m  out  1  ALU mode; 1 = arithmetic/logic, 0 = pass A.
REQ-010 alu_s  out  4  ALU operation select.
REQ-011 alu_cf, alu_zf  in  1 each  combinational carry/zero from the ALU.
REQ-012 rs_sel, rd_sel  out  2 each  register-file source and destination indices.
REQ-013 rf_we  out  1  register-file write strobe, one cycle per ALU instruction.
REQ-014 pc  out  8  program counter.
REQ-015 cf_q, zf_q  out  1 each  registered flags.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 Instruction byte: [7:4] opcode, [3:2] rs, [1:0] rd; jumps carry a second byte (target).
REQ-018 Opcodes: 1001 ADD, 0110 SUB, 1011 AND, 0101 NOT, 1010 MOV, 1100 JMP, 1101 JC, 1110 JZ, 1111 HLT, 0000 and all others NOP.
REQ-019 States: IDLE, FETCH, DECODE, EXEC, WB, OPND; 3-bit one-hot-free binary encoding.
REQ-020 IDLE -> FETCH when start=1; start ignored in other states.
REQ-021 FETCH: mem_req=1; on mem_ack, ir<=mem_rdata, pc<=pc+1 (8-bit wrap, 0xFF->0x00), go DECODE; waits indefinitely without ack.
REQ-022 DECODE (1 cycle): ALU ops -> EXEC; JMP/JC/JZ -> OPND; HLT -> IDLE; NOP -> FETCH.
REQ-023 EXEC (1 cycle): alu_m=1, alu_s=opcode, rs_sel/rd_sel from ir; for ADD/SUB only, cf_q<=alu_cf, zf_q<=alu_zf at end of cycle; AND/NOT/MOV leave flags unchanged.
REQ-024 WB (1 cycle): alu_m, alu_s, selects held from EXEC; rf_we=1; then FETCH.
REQ-025 ALU instruction latency: 4 cycles from FETCH entry to next FETCH with zero-wait ack.
REQ-026 OPND: mem_req=1; on mem_ack, pc<=mem_rdata if taken, else pc<=pc+1; go FETCH; JMP always taken, JC taken iff cf_q=1, JZ iff zf_q=1.
REQ-027 Outside EXEC/WB: alu_m=0, alu_s=0000, rf_we=0.
REQ-028 mem_req=0 in IDLE, DECODE, EXEC, WB.
REQ-029 Jump target byte at 0xFF wraps fall-through pc to 0x00.

Reset
REQ-030 On rst_n=0 (any state, including mid-fetch): state=IDLE, pc=0x00, ir=0x00, cf_q=0, zf_q=0, mem_req=0, alu_m=0, alu_s=0000, rf_we=0, busy=0; a pending ack is discarded.
REQ-031 Outputs held at reset values until first clk edge with rst_n=1 and start=1.

Configuration
REQ-032 Macro COND_BRANCH_EN: defined -> JC/JZ behave per REQ-026; undefined -> 1101/1110 decode as single-byte NOP and flags still update.

Structure
REQ-033 Shared package alu_seq_pkg holds opcode constants, ALU select constants and state enumeration.
REQ-034 One sub-module natural: alu_seq_decode (combinational opcode -> class/alu_s decode); FSM, pc and flags stay in top.

Verification
REQ-035 Reset then start, mem always-ack, byte 0x94 (ADD r1->r0), alu_cf=1, alu_zf=0 -> EXEC alu_s=1001, WB rf_we=1, cf_q=1, pc=0x01, 4 cycles.
REQ-036 SUB with alu_zf=1 then JZ 0x40 -> pc=0x40; with zf_q=0 -> pc=0x03.
REQ-037 pc=0xFF fetch NOP -> pc=0x00.
REQ-038 AND after ADD set cf_q=1 -> cf_q stays 1.
REQ-039 mem_ack withheld 5 cycles in FETCH -> state stays FETCH, pc unchanged; rst_n low mid-wait -> IDLE, pc=0x00.
REQ-040 Build without COND_BRANCH_EN, byte 0xD0 -> treated as NOP, pc advances by 1, next byte fetched as instruction.
